// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state and ALU-op encodings,
// opcode/funct constants, mux select codes and the per-state control word.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EX,
        S_R_WB,
        S_I_EX,
        S_I_WB,
        S_BRANCH,
        S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_AND    = 3'b010,
        ALU_OR     = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_SLT    = 3'b101,
        ALU_ADD_OF = 3'b110
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // Moore control word for a state. r_op is the funct-derived ALU op, used only in R_EX.
    function automatic ctrl_t state_ctrl(state_t s, alu_op_t r_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_R_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = r_op;
            end
            S_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_I_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD_OF;
            end
            // Overflow suppression of this write is applied at the output.
            S_I_WB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_SUB;
                c.pc_source = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_source = PCSRC_JUMP;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic retires(state_t s);
        return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
               (s == S_I_WB)   || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_op_decoder.sv
// R-type funct decoder: maps Funct to the ALU operation and flags unsupported functs.
module mips_multicycle_ctrl_alu_op_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       funct_legal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        alu_op      = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath selects and strobes, and counts retired instructions.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             OF,
    output logic [2:0]       ALU_OP,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             PC_Write,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             Illegal,
    output logic             Ov_Trap,
    output logic [CNT_W-1:0] Instr_Cnt
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q;
    logic             of_q;
    logic [CNT_W-1:0] instr_cnt_q;
    alu_op_t          r_alu_op;
    logic             funct_legal;
    logic             decode_illegal;

    mips_multicycle_ctrl_alu_op_decoder u_alu_op_decoder (
        .funct       (Funct),
        .alu_op      (r_alu_op),
        .funct_legal (funct_legal)
    );

    always_comb begin
        state_d        = state_q;
        decode_illegal = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct_legal) state_d = S_R_EX;
                        else             decode_illegal = 1'b1;
                    end
                    OP_ADDI: state_d = S_I_EX;
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
                    default: decode_illegal = 1'b1;
                endcase
                if (decode_illegal) state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_R_EX:     state_d = S_R_WB;
            S_I_EX:     state_d = S_I_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                        state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    // Control word is registered against the next state, so it is glitch-free and
    // cleared by the asynchronous reset along with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            of_q        <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, r_alu_op);
            if (state_q == S_I_EX) of_q <= OF;
            if (retires(state_q))  instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign ALU_OP    = ctrl_q.alu_op;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign PCSource  = ctrl_q.pc_source;
    // The branch decision is the only Mealy term: Zero arrives in the BRANCH cycle itself.
    assign PC_Write  = ctrl_q.pc_write | ((state_q == S_BRANCH) & Zero);
    assign IorD      = ctrl_q.iord;
    assign MemRead   = ctrl_q.mem_read;
    assign MemWrite  = ctrl_q.mem_write;
    assign IRWrite   = ctrl_q.ir_write;
    assign RegDst    = ctrl_q.reg_dst;
    assign MemtoReg  = ctrl_q.mem_to_reg;
    assign Ov_Trap   = (state_q == S_I_WB) & of_q;
    assign RegWrite  = ctrl_q.reg_write & ~Ov_Trap;
    assign Illegal   = (state_q == S_DECODE) & decode_illegal;
    assign Instr_Cnt = instr_cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a per-instruction micro-sequence model
// feeds an expectation queue that is compared against the DUT every cycle.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op, funct;
    logic        zero, of;
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic        pc_write, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, illegal, ov_trap;
    logic [31:0] instr_cnt;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Op        (op),
        .Funct     (funct),
        .Zero      (zero),
        .OF        (of),
        .ALU_OP    (alu_op),
        .ALUSrcA   (alu_src_a),
        .ALUSrcB   (alu_src_b),
        .PCSource  (pc_source),
        .PC_Write  (pc_write),
        .IorD      (iord),
        .MemRead   (mem_read),
        .MemWrite  (mem_write),
        .IRWrite   (ir_write),
        .RegDst    (reg_dst),
        .MemtoReg  (mem_to_reg),
        .RegWrite  (reg_write),
        .Illegal   (illegal),
        .Ov_Trap   (ov_trap),
        .Instr_Cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, illegal, ov_trap;
    } word_t;

    typedef struct {
        word_t       w;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model_cnt  = 0;
    int          fetch_seen = 0;
    int          ov_seen    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic word_t dut_word();
        return {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, iord, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, ov_trap};
    endfunction

    // Compare process: one expected control word and counter value per clock cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, " ctrl"}, 32'(dut_word()), 32'(e.w));
            check({e.tag, " cnt"}, instr_cnt, e.cnt);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ir_write) fetch_seen++;
            if (ov_trap)  ov_seen++;
        end
    end

    // Model: the cycle-by-cycle control words an instruction must produce, from fetch to retire.
    function automatic void build_seq(input logic [5:0] o, input logic [5:0] f, input logic z,
                                      input logic ovf, output word_t seq[$], output logic legal);
        word_t w;
        logic  r_ok;
        logic [2:0] r_alu;
        r_ok  = 1'b1;
        r_alu = 3'b000;
        case (f)
            6'h20: r_alu = 3'b000;
            6'h22: r_alu = 3'b001;
            6'h24: r_alu = 3'b010;
            6'h25: r_alu = 3'b011;
            6'h26: r_alu = 3'b100;
            6'h2A: r_alu = 3'b101;
            default: r_ok = 1'b0;
        endcase
        legal = (o == 6'h23) || (o == 6'h2B) || (o == 6'h08) || (o == 6'h04) ||
                (o == 6'h02) || ((o == 6'h00) && r_ok);
        seq = {};
        w = '0; w.mem_read = 1; w.ir_write = 1; w.pc_write = 1; w.src_b = 2'b01;
        seq.push_back(w);
        w = '0; w.src_b = 2'b11; w.illegal = !legal;
        seq.push_back(w);
        if (!legal) return;
        case (o)
            6'h23, 6'h2B: begin
                w = '0; w.src_a = 1; w.src_b = 2'b10;
                seq.push_back(w);
                if (o == 6'h23) begin
                    w = '0; w.iord = 1; w.mem_read = 1;     seq.push_back(w);
                    w = '0; w.mem_to_reg = 1; w.reg_write = 1; seq.push_back(w);
                end else begin
                    w = '0; w.iord = 1; w.mem_write = 1;    seq.push_back(w);
                end
            end
            6'h00: begin
                w = '0; w.src_a = 1; w.alu_op = r_alu;      seq.push_back(w);
                w = '0; w.reg_dst = 1; w.reg_write = 1;     seq.push_back(w);
            end
            6'h08: begin
                w = '0; w.src_a = 1; w.src_b = 2'b10; w.alu_op = 3'b110; seq.push_back(w);
                w = '0; w.reg_write = !ovf; w.ov_trap = ovf;              seq.push_back(w);
            end
            6'h04: begin
                w = '0; w.src_a = 1; w.alu_op = 3'b001; w.pc_src = 2'b01; w.pc_write = z;
                seq.push_back(w);
            end
            default: begin
                w = '0; w.pc_src = 2'b10; w.pc_write = 1;   seq.push_back(w);
            end
        endcase
    endfunction

    // Called at posedge+1 of the FETCH cycle; returns at posedge+1 of the next FETCH.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input logic ovf);
        word_t seq[$];
        logic  legal;
        op = o; funct = f; zero = z; of = ovf;
        build_seq(o, f, z, ovf, seq, legal);
        foreach (seq[i]) exp_q.push_back('{seq[i], model_cnt, $sformatf("%s c%0d", tag, i)});
        repeat (seq.size()) begin
            @(posedge clk);
            #1;
        end
        if (legal) model_cnt++;
    endtask

    task automatic push_reset_cycle(input string tag);
        exp_q.push_back('{word_t'('0), 32'd0, tag});
    endtask

    initial begin
        word_t seq[$];
        logic  legal;
        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; of = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", 32'(dut_word()), 32'd0);
        check("reset cnt", instr_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_reset_cycle("idle");
        @(posedge clk); #1;

        run_instr("add",   6'h00, 6'h20, 1'b0, 1'b1);
        check("cnt after add", instr_cnt, 32'd1);
        run_instr("sub",   6'h00, 6'h22, 1'b0, 1'b0);
        run_instr("and",   6'h00, 6'h24, 1'b1, 1'b0);
        run_instr("or",    6'h00, 6'h25, 1'b0, 1'b1);
        run_instr("xor",   6'h00, 6'h26, 1'b0, 1'b0);
        run_instr("slt",   6'h00, 6'h2A, 1'b0, 1'b0);
        run_instr("addi_of",  6'h08, 6'h11, 1'b0, 1'b1);
        run_instr("addi_ok",  6'h08, 6'h11, 1'b0, 1'b0);
        run_instr("beq_tkn",  6'h04, 6'h00, 1'b1, 1'b0);
        run_instr("beq_ntkn", 6'h04, 6'h00, 1'b0, 1'b1);
        run_instr("lw",    6'h23, 6'h05, 1'b0, 1'b1);
        run_instr("sw",    6'h2B, 6'h2A, 1'b1, 1'b0);
        run_instr("j",     6'h02, 6'h00, 1'b0, 1'b0);
        run_instr("ill_op",    6'h3F, 6'h20, 1'b0, 1'b0);
        run_instr("ill_funct", 6'h00, 6'h00, 1'b0, 1'b0);
        check("cnt after illegals", instr_cnt, 32'd13);

        // lw interrupted by reset in MEM_RD: only the first three cycles complete.
        op = 6'h23; funct = 6'h00; zero = 1'b0; of = 1'b0;
        build_seq(op, funct, zero, of, seq, legal);
        for (int i = 0; i < 3; i++) exp_q.push_back('{seq[i], model_cnt, $sformatf("lw_rst c%0d", i)});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        model_cnt = 0;
        push_reset_cycle("rst_hold0");
        push_reset_cycle("rst_hold1");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        push_reset_cycle("idle2");
        @(posedge clk); #1;

        run_instr("add2", 6'h00, 6'h20, 1'b0, 1'b0);
        check("cnt after reset+add", instr_cnt, 32'd1);
        check("fetch pulses", 32'(fetch_seen), 32'd17);
        check("ov_trap pulses", 32'(ov_seen), 32'd1);
        check("expectations drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
